// File: rtl/mem_access_unit_if.sv
// Data-SRAM request/response bus between the load/store unit (master)
// and the data memory (slave).
interface mem_access_unit_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic                  data_req;
  logic                  data_wr;
  logic [1:0]            data_size;
  logic [ADDR_W-1:0]     data_addr;
  logic [DATA_W/8-1:0]   data_wstrb;
  logic [DATA_W-1:0]     data_wdata;
  logic                  data_addr_ok;
  logic                  data_data_ok;
  logic [DATA_W-1:0]     data_rdata;

  modport master (
    output data_req, data_wr, data_size, data_addr, data_wstrb, data_wdata,
    input  data_addr_ok, data_data_ok, data_rdata
  );

  modport slave (
    input  data_req, data_wr, data_size, data_addr, data_wstrb, data_wdata,
    output data_addr_ok, data_data_ok, data_rdata
  );
endinterface

// File: rtl/mem_access_unit.sv
// Memory-stage load/store unit: issues one aligned access per decoded load or
// store on the data-SRAM bus, stalls the pipeline until it completes.
module mem_access_unit #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              req_valid,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [1:0]        mem_size,
  input  logic              mem_unsigned,
  input  logic              flush,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              mem_stall,
  output logic [DATA_W-1:0] load_data,
  output logic              resp_valid,
  output logic              adel,
  output logic              ades,
  output logic [ADDR_W-1:0] bad_vaddr,
  mem_access_unit_if.master dbus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] WAIT = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic [1:0]        state_q, state_d;
  logic              isWrite_q, isWrite_d;
  logic [1:0]        size_q, size_d;
  logic              isUnsigned_q, isUnsigned_d;
  logic [1:0]        lane_q, lane_d;
  logic              drop_q, drop_d;
  logic              dataReq_q, dataReq_d;
  logic              dataWr_q, dataWr_d;
  logic [1:0]        dataSize_q, dataSize_d;
  logic [ADDR_W-1:0] dataAddr_q, dataAddr_d;
  logic [3:0]        dataWstrb_q, dataWstrb_d;
  logic [DATA_W-1:0] dataWdata_q, dataWdata_d;
  logic [DATA_W-1:0] loadData_q, loadData_d;

  logic              validOp, misaligned, acceptOp, busy, draining;
  logic [3:0]        laneStrb;
  logic [DATA_W-1:0] laneWdata;
  logic [7:0]        byteSel;
  logic [15:0]       halfSel;
  logic [DATA_W-1:0] extended;

  assign validOp    = req_valid & ~flush & (mem_read ^ mem_write);
  assign misaligned = (mem_size == 2'd3) |
                      ((mem_size == 2'd1) & addr[0]) |
                      ((mem_size == 2'd2) & (|addr[1:0]));
  assign acceptOp   = (state_q == IDLE) & validOp & ~misaligned;
  assign busy       = (state_q == REQ) | (state_q == WAIT);
  assign draining   = drop_q & (state_q != IDLE);

  // A flushed access keeps draining on the bus but releases the pipeline;
  // a follow-on op must still wait for the FSM to get back to IDLE.
  assign mem_stall  = resetn & (acceptOp | (busy & ~drop_q & ~flush) | (draining & validOp));
  assign resp_valid = (state_q == DONE) & ~drop_q;
  assign adel       = resetn & (state_q == IDLE) & validOp & misaligned & mem_read;
  assign ades       = resetn & (state_q == IDLE) & validOp & misaligned & mem_write;
  assign bad_vaddr  = (adel | ades) ? addr : '0;

  always_comb begin
    laneStrb  = 4'b0000;
    laneWdata = '0;
    if (mem_write) begin
      case (mem_size)
        2'd0: begin
          laneStrb  = 4'b0001 << addr[1:0];
          laneWdata = {4{wdata[7:0]}};
        end
        2'd1: begin
          laneStrb  = addr[1] ? 4'b1100 : 4'b0011;
          laneWdata = {2{wdata[15:0]}};
        end
        default: begin
          laneStrb  = 4'b1111;
          laneWdata = wdata;
        end
      endcase
    end
  end

  always_comb begin
    byteSel  = dbus.data_rdata[{lane_q, 3'b000} +: 8];
    halfSel  = lane_q[1] ? dbus.data_rdata[31:16] : dbus.data_rdata[15:0];
    extended = dbus.data_rdata;
    case (size_q)
      2'd0:    extended = {{24{~isUnsigned_q & byteSel[7]}}, byteSel};
      2'd1:    extended = {{16{~isUnsigned_q & halfSel[15]}}, halfSel};
      default: extended = dbus.data_rdata;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    isWrite_d    = isWrite_q;
    size_d       = size_q;
    isUnsigned_d = isUnsigned_q;
    lane_d       = lane_q;
    drop_d       = drop_q;
    dataReq_d    = dataReq_q;
    dataWr_d     = dataWr_q;
    dataSize_d   = dataSize_q;
    dataAddr_d   = dataAddr_q;
    dataWstrb_d  = dataWstrb_q;
    dataWdata_d  = dataWdata_q;
    loadData_d   = loadData_q;
    case (state_q)
      IDLE: begin
        if (acceptOp) begin
          state_d      = REQ;
          isWrite_d    = mem_write;
          size_d       = mem_size;
          isUnsigned_d = mem_unsigned;
          lane_d       = addr[1:0];
          drop_d       = 1'b0;
          dataReq_d    = 1'b1;
          dataWr_d     = mem_write;
          dataSize_d   = mem_size;
          dataAddr_d   = {addr[ADDR_W-1:2], 2'b00};
          dataWstrb_d  = laneStrb;
          dataWdata_d  = laneWdata;
        end
      end
      REQ: begin
        if (flush) drop_d = 1'b1;
        if (dbus.data_addr_ok) begin
          dataReq_d = 1'b0;
          state_d   = dbus.data_data_ok ? DONE : WAIT;
          if (dbus.data_data_ok & ~isWrite_q & ~drop_q & ~flush) loadData_d = extended;
        end
      end
      WAIT: begin
        if (flush) drop_d = 1'b1;
        if (dbus.data_data_ok) begin
          state_d = DONE;
          if (~isWrite_q & ~drop_q & ~flush) loadData_d = extended;
        end
      end
      DONE: begin
        state_d = IDLE;
        drop_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= IDLE;
      isWrite_q    <= 1'b0;
      size_q       <= 2'd0;
      isUnsigned_q <= 1'b0;
      lane_q       <= 2'd0;
      drop_q       <= 1'b0;
      dataReq_q    <= 1'b0;
      dataWr_q     <= 1'b0;
      dataSize_q   <= 2'd0;
      dataAddr_q   <= '0;
      dataWstrb_q  <= 4'b0000;
      dataWdata_q  <= '0;
      loadData_q   <= '0;
    end else begin
      state_q      <= state_d;
      isWrite_q    <= isWrite_d;
      size_q       <= size_d;
      isUnsigned_q <= isUnsigned_d;
      lane_q       <= lane_d;
      drop_q       <= drop_d;
      dataReq_q    <= dataReq_d;
      dataWr_q     <= dataWr_d;
      dataSize_q   <= dataSize_d;
      dataAddr_q   <= dataAddr_d;
      dataWstrb_q  <= dataWstrb_d;
      dataWdata_q  <= dataWdata_d;
      loadData_q   <= loadData_d;
    end
  end

  assign dbus.data_req   = dataReq_q;
  assign dbus.data_wr    = dataWr_q;
  assign dbus.data_size  = dataSize_q;
  assign dbus.data_addr  = dataAddr_q;
  assign dbus.data_wstrb = dataWstrb_q;
  assign dbus.data_wdata = dataWdata_q;
  assign load_data       = loadData_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed vector table, flush/no-op/reset
// sequences, and randomized accesses against an arithmetic reference model.
module tb_mem_access_unit;

  typedef struct {
    string       name;
    logic        wr;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          addrDelay;
    int          dataDelay;
    logic        expErr;
    logic [31:0] expLoad;
    logic [31:0] expBusAddr;
    logic [3:0]  expStrb;
    logic [31:0] expWdata;
  } vec_t;

  logic        clk;
  logic        resetn;
  logic        reqValid, memRead, memWrite, memUnsigned, flush;
  logic [1:0]  memSize;
  logic [31:0] addr, wdata;
  logic        memStall, respValid, adel, ades;
  logic [31:0] loadData, badVaddr;

  int          checks;
  int          errors;
  logic [31:0] modelLoad;
  vec_t        vecs[12];

  mem_access_unit_if #(.ADDR_W(32), .DATA_W(32)) dbus ();

  mem_access_unit #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .req_valid    (reqValid),
    .mem_read     (memRead),
    .mem_write    (memWrite),
    .mem_size     (memSize),
    .mem_unsigned (memUnsigned),
    .flush        (flush),
    .addr         (addr),
    .wdata        (wdata),
    .mem_stall    (memStall),
    .load_data    (loadData),
    .resp_valid   (respValid),
    .adel         (adel),
    .ades         (ades),
    .bad_vaddr    (badVaddr),
    .dbus         (dbus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
    end
  endtask

  function automatic bit mdlMisaligned(input logic [1:0] size, input logic [31:0] a);
    int off;
    off = int'(a % 4);
    return (size == 2'd3) || (size == 2'd1 && off % 2 == 1) || (size == 2'd2 && off != 0);
  endfunction

  function automatic logic [31:0] mdlLoad(input logic [31:0] rd, input logic [1:0] size,
                                          input logic uns, input logic [31:0] a);
    int off;
    longint v;
    off = int'(a % 4);
    if (size == 2'd0) begin
      v = longint'((rd >> (8 * off)) & 32'hFF);
      if (!uns && v >= 128) v = v - 256;
    end else if (size == 2'd1) begin
      v = longint'((off >= 2 ? rd >> 16 : rd) & 32'hFFFF);
      if (!uns && v >= 32768) v = v - 65536;
    end else begin
      v = longint'(rd);
    end
    return v[31:0];
  endfunction

  function automatic logic [3:0] mdlStrb(input logic wr, input logic [1:0] size, input logic [31:0] a);
    int off;
    off = int'(a % 4);
    if (!wr) return 4'd0;
    if (size == 2'd0) return 4'(1 << off);
    if (size == 2'd1) return (off >= 2) ? 4'd12 : 4'd3;
    return 4'd15;
  endfunction

  function automatic logic [31:0] mdlWdata(input logic [1:0] size, input logic [31:0] wd);
    if (size == 2'd0) return (wd & 32'hFF) * 32'h0101_0101;
    if (size == 2'd1) return (wd & 32'hFFFF) * 32'h0001_0001;
    return wd;
  endfunction

  // One complete access; the bench plays the memory slave with the vector's
  // addr_ok/data_ok delays and checks the whole transaction afterwards.
  task automatic applyStimulus(input vec_t v);
    int          stallCnt, respCnt, reqWait, acceptCycle, doneCyc;
    bit          accepted, dataSent, seenReq, stable, finished;
    logic [31:0] respLoad, fAddr, fWdata;
    logic [3:0]  fStrb;
    logic        fWr;
    logic [1:0]  fSize;
    stallCnt = 0; respCnt = 0; reqWait = 0; acceptCycle = 0; doneCyc = -1;
    accepted = 0; dataSent = 0; seenReq = 0; stable = 1; finished = 0;
    respLoad = '0; fAddr = '0; fWdata = '0; fStrb = '0; fWr = 0; fSize = '0;
    reqValid = 1; memRead = ~v.wr; memWrite = v.wr; memSize = v.size;
    memUnsigned = v.uns; addr = v.addr; wdata = v.wdata; flush = 0;
    dbus.data_rdata = v.rdata;
    dbus.data_addr_ok = 0; dbus.data_data_ok = 0;
    if (v.expErr) begin
      @(negedge clk);
      checkOutput({v.name, ".adel"}, {31'd0, adel}, {31'd0, ~v.wr});
      checkOutput({v.name, ".ades"}, {31'd0, ades}, {31'd0, v.wr});
      checkOutput({v.name, ".badVaddr"}, badVaddr, v.addr);
      checkOutput({v.name, ".stall"}, {31'd0, memStall}, 32'd0);
      @(posedge clk); #1;
      @(negedge clk);
      checkOutput({v.name, ".noReq"}, {31'd0, dbus.data_req}, 32'd0);
      @(posedge clk); #1;
      reqValid = 0;
      return;
    end
    for (int cyc = 0; cyc < 64 && !finished; cyc++) begin
      dbus.data_addr_ok = 0;
      dbus.data_data_ok = 0;
      if (dbus.data_req && !accepted) begin
        if (reqWait >= v.addrDelay) begin
          dbus.data_addr_ok = 1;
          accepted = 1;
          acceptCycle = cyc;
          if (v.dataDelay == 0) begin
            dbus.data_data_ok = 1;
            dataSent = 1;
          end
        end
      end else if (accepted && !dataSent && (cyc - acceptCycle) >= v.dataDelay) begin
        dbus.data_data_ok = 1;
        dataSent = 1;
      end
      @(negedge clk);
      if (memStall) stallCnt++;
      if (respValid) begin
        respCnt++;
        respLoad = loadData;
        if (doneCyc < 0) doneCyc = cyc;
      end
      if (dbus.data_req) begin
        if (!seenReq) begin
          seenReq = 1;
          fAddr = dbus.data_addr; fWdata = dbus.data_wdata; fStrb = dbus.data_wstrb;
          fWr = dbus.data_wr; fSize = dbus.data_size;
        end else if ({fAddr, fWdata, fStrb, fWr, fSize} !==
                     {dbus.data_addr, dbus.data_wdata, dbus.data_wstrb, dbus.data_wr, dbus.data_size}) begin
          stable = 0;
        end
        if (!dbus.data_addr_ok) reqWait++;
      end
      if (doneCyc >= 0 && cyc > doneCyc) finished = 1;
      @(posedge clk); #1;
      if (doneCyc >= 0) reqValid = 0;
    end
    dbus.data_addr_ok = 0;
    dbus.data_data_ok = 0;
    reqValid = 0;
    if (!v.wr) modelLoad = v.expLoad;
    checkOutput({v.name, ".respCount"}, respCnt, 32'd1);
    checkOutput({v.name, ".stallCycles"}, stallCnt, 32'(2 + v.addrDelay + v.dataDelay));
    checkOutput({v.name, ".busAddr"}, fAddr, v.expBusAddr);
    checkOutput({v.name, ".busWr"}, {31'd0, fWr}, {31'd0, v.wr});
    checkOutput({v.name, ".busSize"}, {30'd0, fSize}, {30'd0, v.size});
    checkOutput({v.name, ".busStrb"}, {28'd0, fStrb}, {28'd0, v.expStrb});
    if (v.wr) checkOutput({v.name, ".busWdata"}, fWdata, v.expWdata);
    checkOutput({v.name, ".busStable"}, {31'd0, stable}, 32'd1);
    checkOutput({v.name, ".loadData"}, respLoad, modelLoad);
  endtask

  initial begin
    checks = 0; errors = 0; modelLoad = '0;
    resetn = 0; reqValid = 0; memRead = 0; memWrite = 0; memSize = 0;
    memUnsigned = 0; flush = 0; addr = 0; wdata = 0;
    dbus.data_addr_ok = 0; dbus.data_data_ok = 0; dbus.data_rdata = 0;

    vecs[0]  = '{"lw100",  0, 2'd2, 0, 32'h100, 32'h0,         32'hDEAD_BEEF, 0, 0, 0, 32'hDEAD_BEEF, 32'h100, 4'h0, 32'h0};
    vecs[1]  = '{"lb203",  0, 2'd0, 0, 32'h203, 32'h0,         32'h80FF_0000, 0, 0, 0, 32'hFFFF_FF80, 32'h200, 4'h0, 32'h0};
    vecs[2]  = '{"lbu203", 0, 2'd0, 1, 32'h203, 32'h0,         32'h80FF_0000, 0, 0, 0, 32'h0000_0080, 32'h200, 4'h0, 32'h0};
    vecs[3]  = '{"sh12",   1, 2'd1, 0, 32'h12,  32'h0000_ABCD, 32'h0,         0, 0, 0, 32'h0,         32'h10,  4'hC, 32'hABCD_ABCD};
    vecs[4]  = '{"lw102",  0, 2'd2, 0, 32'h102, 32'h0,         32'h0,         0, 0, 1, 32'h0,         32'h0,   4'h0, 32'h0};
    vecs[5]  = '{"sw101",  1, 2'd2, 0, 32'h101, 32'h0,         32'h0,         0, 0, 1, 32'h0,         32'h0,   4'h0, 32'h0};
    vecs[6]  = '{"lwSlow", 0, 2'd2, 0, 32'h20,  32'h0,         32'h0BAD_F00D, 3, 2, 0, 32'h0BAD_F00D, 32'h20,  4'h0, 32'h0};
    vecs[7]  = '{"lh202",  0, 2'd1, 0, 32'h202, 32'h0,         32'h8001_1234, 1, 1, 0, 32'hFFFF_8001, 32'h200, 4'h0, 32'h0};
    vecs[8]  = '{"lhu200", 0, 2'd1, 1, 32'h200, 32'h0,         32'h1234_F00D, 0, 3, 0, 32'h0000_F00D, 32'h200, 4'h0, 32'h0};
    vecs[9]  = '{"sb007",  1, 2'd0, 0, 32'h7,   32'h1234_565A, 32'h0,         2, 0, 0, 32'h0,         32'h4,   4'h8, 32'h5A5A_5A5A};
    vecs[10] = '{"sw008",  1, 2'd2, 0, 32'h8,   32'h1234_5678, 32'h0,         0, 1, 0, 32'h0,         32'h8,   4'hF, 32'h1234_5678};
    vecs[11] = '{"lres",   0, 2'd3, 0, 32'h40,  32'h0,         32'h0,         0, 0, 1, 32'h0,         32'h0,   4'h0, 32'h0};

    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst.dataReq", {31'd0, dbus.data_req}, 32'd0);
    checkOutput("rst.dataWr", {31'd0, dbus.data_wr}, 32'd0);
    checkOutput("rst.stall", {31'd0, memStall}, 32'd0);
    checkOutput("rst.resp", {31'd0, respValid}, 32'd0);
    checkOutput("rst.errs", {30'd0, adel, ades}, 32'd0);
    checkOutput("rst.dataAddr", dbus.data_addr, 32'd0);
    checkOutput("rst.dataWdata", dbus.data_wdata, 32'd0);
    checkOutput("rst.strbSize", {26'd0, dbus.data_wstrb, dbus.data_size}, 32'd0);
    checkOutput("rst.loadData", loadData, 32'd0);
    resetn = 1;
    @(posedge clk); #1;

    for (int i = 0; i < 12; i++) applyStimulus(vecs[i]);

    // Read and write together is a no-op; flush in IDLE masks even a misaligned op.
    reqValid = 1; memRead = 1; memWrite = 1; memSize = 2'd2; addr = 32'h80;
    @(negedge clk);
    checkOutput("noop.stall", {31'd0, memStall}, 32'd0);
    checkOutput("noop.adel", {31'd0, adel}, 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("noop.noReq", {31'd0, dbus.data_req}, 32'd0);
    @(posedge clk); #1;
    memWrite = 0; addr = 32'h81; flush = 1;
    @(negedge clk);
    checkOutput("idleFlush.stall", {31'd0, memStall}, 32'd0);
    checkOutput("idleFlush.adel", {31'd0, adel}, 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("idleFlush.noReq", {31'd0, dbus.data_req}, 32'd0);
    @(posedge clk); #1;
    flush = 0; reqValid = 0;

    // Flush during WAIT: stall drops, transaction drains, no response, then a new LW.
    reqValid = 1; memRead = 1; memWrite = 0; memSize = 2'd2; memUnsigned = 0;
    addr = 32'h40; dbus.data_rdata = 32'h1111_1111;
    @(negedge clk);
    checkOutput("flush.idleStall", {31'd0, memStall}, 32'd1);
    @(posedge clk); #1;
    dbus.data_addr_ok = 1;
    @(negedge clk);
    checkOutput("flush.reqUp", {31'd0, dbus.data_req}, 32'd1);
    @(posedge clk); #1;
    dbus.data_addr_ok = 0; flush = 1;
    @(negedge clk);
    checkOutput("flush.stallDrop", {31'd0, memStall}, 32'd0);
    @(posedge clk); #1;
    flush = 0; addr = 32'h44;
    @(negedge clk);
    checkOutput("flush.drainStall", {31'd0, memStall}, 32'd1);
    @(posedge clk); #1;
    dbus.data_data_ok = 1;
    @(negedge clk);
    checkOutput("flush.respDataCyc", {31'd0, respValid}, 32'd0);
    @(posedge clk); #1;
    dbus.data_data_ok = 0;
    @(negedge clk);
    checkOutput("flush.noResp", {31'd0, respValid}, 32'd0);
    checkOutput("flush.loadHeld", loadData, modelLoad);
    checkOutput("flush.stallTillIdle", {31'd0, memStall}, 32'd1);
    @(posedge clk); #1;
    applyStimulus('{"lw44", 0, 2'd2, 0, 32'h44, 32'h0, 32'h4444_4444, 0, 0, 0,
                    32'h4444_4444, 32'h44, 4'h0, 32'h0});

    for (int i = 0; i < 40; i++) begin
      vec_t r;
      r.name = $sformatf("rnd%0d", i);
      r.wr = 1'($urandom_range(0, 1));
      r.size = 2'($urandom_range(0, 3));
      r.uns = 1'($urandom_range(0, 1));
      r.addr = $urandom;
      r.wdata = $urandom;
      r.rdata = $urandom;
      r.addrDelay = $urandom_range(0, 3);
      r.dataDelay = $urandom_range(0, 3);
      r.expErr = mdlMisaligned(r.size, r.addr);
      r.expLoad = mdlLoad(r.rdata, r.size, r.uns, r.addr);
      r.expBusAddr = r.addr - (r.addr % 4);
      r.expStrb = mdlStrb(r.wr, r.size, r.addr);
      r.expWdata = mdlWdata(r.size, r.wdata);
      applyStimulus(r);
    end

    // Asynchronous reset in the middle of a request drops data_req at once.
    reqValid = 1; memRead = 1; memWrite = 0; memSize = 2'd2; addr = 32'h300;
    @(posedge clk); #1;
    checkOutput("midRst.reqUp", {31'd0, dbus.data_req}, 32'd1);
    resetn = 0;
    #1;
    checkOutput("midRst.reqDrop", {31'd0, dbus.data_req}, 32'd0);
    checkOutput("midRst.stall", {31'd0, memStall}, 32'd0);
    checkOutput("midRst.dataAddr", dbus.data_addr, 32'd0);
    checkOutput("midRst.loadData", loadData, 32'd0);
    @(posedge clk); #1;
    reqValid = 0; resetn = 1;
    @(posedge clk); #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Memory-stage load/store unit; the downstream consumer of the main decoder's memRead/memWrite/memToReg controls.
- Turns one decoded load or store into a transaction on the data-SRAM request/response bus, and handles byte-lane alignment and sign/zero extension.
- Stalls the pipeline until the access completes.
- Sits between the EX/MEM pipeline register and the data-memory bus.

Parameters:
- ADDR_W, 32, data address width
- DATA_W, 32, data bus width; fixed at 32, the lane logic assumes 4 bytes

Ports:
- clk  in  1  system clock
- resetn  in  1  asynchronous reset, active-low
- req_valid  in  1  a memory instruction is present in MEM
- mem_read  in  1  load (LB/LBU/LH/LHU/LW)
- mem_write  in  1  store (SB/SH/SW)
- mem_size  in  2  0=byte, 1=half, 2=word, 3=reserved
- mem_unsigned  in  1  zero-extend the load (LBU/LHU)
- flush  in  1  discard the current instruction (exception/redirect)
- addr  in  32  effective address
- wdata  in  32  store data, taken from rt
- mem_stall  out  1  hold the pipeline
- load_data  out  32  extended load result
- resp_valid  out  1  one-cycle pulse: access complete, load_data valid
- adel  out  1  load address error
- ades  out  1  store address error
- bad_vaddr  out  32  faulting address
- data_req  out  1  bus request
- data_wr  out  1  1=write
- data_size  out  2  0/1/2 = 1/2/4 bytes
- data_addr  out  32  bus address
- data_wstrb  out  4  byte strobes
- data_wdata  out  32  lane-replicated store data
- data_addr_ok  in  1  request accepted
- data_data_ok  in  1  data returned / write done
- data_rdata  in  32  read data

Behaviour:
- Reset: state IDLE. data_req, data_wr, resp_valid, mem_stall, adel and ades are 0. data_size, data_addr, data_wstrb, data_wdata and load_data are all 0.
- Alignment check:
  - Misaligned when size=half and addr[0]=1, or size=word and addr[1:0]!=0.
  - size=3 counts as misaligned.
- Valid op: req_valid & !flush & (mem_read XOR mem_write). Read and write both high counts as no-op: no request, no stall.
- States: IDLE, REQ, WAIT, DONE.
- IDLE:
  - Valid op, misaligned: no request. adel (read) or ades (write) is asserted combinationally that same cycle, bad_vaddr=addr, mem_stall=0, state stays IDLE.
  - Valid op, aligned: latch op/size/unsigned/addr[1:0]. Register data_req=1 and the bus fields. mem_stall=1. Next state REQ.
- REQ:
  - data_req=1. All bus fields are held stable until data_addr_ok=1.
  - On addr_ok, data_req drops the next cycle.
  - Next state is WAIT, or DONE if data_data_ok is also high that cycle.
- WAIT: when data_data_ok=1, capture data_rdata into load_data (loads only) and go to DONE. data_ok is ignored in IDLE.
- DONE: resp_valid=1, mem_stall=0. Next state is always IDLE, unconditionally.
- mem_stall = (IDLE & valid aligned op) | REQ | WAIT.
- Minimum latency is 2 stall cycles, with addr_ok and data_ok both high in the first REQ cycle.
- Bus address: data_addr = {addr[31:2],2'b00}.
- Store lanes:
  - Byte: data_wdata = {4{wdata[7:0]}}, data_wstrb = 4'b0001 << addr[1:0].
  - Half: data_wdata = {2{wdata[15:0]}}, data_wstrb = addr[1] ? 1100 : 0011.
  - Word: data_wdata = wdata, data_wstrb = 1111.
  - Loads: data_wstrb = 0000.
- Load extract:
  - Byte: data_rdata[8*a+7:8*a], where a = latched addr[1:0].
  - Half: the upper half if a[1], else the lower half.
  - Sign-extend, or zero-extend when unsigned.
  - load_data holds its value until the next load completes.
- Flush:
  - In IDLE it suppresses a new request.
  - In REQ or WAIT the bus transaction is not withdrawn. A drop flag is set, the handshake completes, load_data is not updated, and resp_valid is not asserted.
  - mem_stall deasserts as soon as flush is seen in REQ/WAIT. The FSM still finishes internally and returns to IDLE.
  - While draining (REQ/WAIT with drop set), a new valid op is not accepted. mem_stall=1 for that op until the FSM is back in IDLE.
- resetn low in any state: immediate return to IDLE with all outputs at reset values, including dropping data_req mid-request.

Test Plan:
- LW addr=0x100, bus returns 0xDEADBEEF with addr_ok and data_ok in the first REQ cycle -> mem_stall high 2 cycles, then resp_valid=1, load_data=0xDEADBEEF.
- LB addr=0x203, data_rdata=0x80FF_0000 -> load_data=0xFFFF_FF80; LBU at the same address -> 0x0000_0080.
- SH addr=0x12, wdata=0x0000_ABCD -> data_wr=1, data_addr=0x10, data_wstrb=1100, data_wdata=0xABCD_ABCD.
- LW addr=0x102 -> adel=1 and bad_vaddr=0x102 the same cycle, data_req never rises, mem_stall=0. SW addr=0x101 -> ades=1.
- addr_ok held low 3 cycles -> data_req and all bus fields stable across those cycles. data_ok arrives 2 cycles after addr_ok -> resp_valid exactly once.
- Flush asserted while in WAIT -> mem_stall drops immediately, the transaction drains, no resp_valid, load_data keeps its old value. Next LW completes normally.
